// File: rtl/pipelined_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_addsub
//   Pipelined ripple-carry adder/subtractor. The WIDTH-bit carry chain is cut
//   into STAGES segments of CHUNK = WIDTH/STAGES bits. Each segment adds one
//   chunk and registers its sum bits and carry out. Operands ride along the
//   pipe so that the upper chunks are used later. Finished sum chunks ride
//   along too, so every word leaves the pipe with all of its bits aligned.
//   The whole pipe advances on a single enable. A stall therefore freezes
//   every stage uniformly, and bubbles travel with the data.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands present
//   in_ready   out  operands accepted this cycle (= !out_valid | out_ready)
//   a, b       in   WIDTH-bit operands
//   carry_in   in   carry into bit 0 (add mode only)
//   sub        in   0: a+b+carry_in, 1: a-b (a + ~b + 1)
//   out_valid  out  result present
//   out_ready  in   downstream accepts result
//   sum        out  WIDTH-bit result, modulo 2^WIDTH
//   carry_out  out  carry out of the MSB (subtract: 1 = no borrow)
//   overflow   out  signed two's-complement overflow
// -----------------------------------------------------------------------------
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES");
  end

  // Level 0 holds the captured operands. Level k+1 holds the word after
  // segment k has added its chunk. Level STAGES is the output register.
  logic             v_q [0:STAGES];
  logic             c_q [0:STAGES];
  logic [WIDTH-1:0] r_q [0:STAGES];
  logic [WIDTH-1:0] a_q [0:STAGES-1];
  logic [WIDTH-1:0] b_q [0:STAGES-1];
  logic             ovf_q;

  logic                         adv_s;
  logic [STAGES-1:0]            cn_d;
  logic [STAGES-1:0][WIDTH-1:0] r_d;
  logic                         msb_cin_s;
  logic                         ovf_d;

  assign adv_s    = !v_q[STAGES] || out_ready;
  assign in_ready = adv_s;

  // One ripple segment per stage. It adds its own chunk and merges the
  // result into the partial sum word.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK:0] add_s;

    assign add_s = {1'b0, a_q[k][k*CHUNK +: CHUNK]}
                 + {1'b0, b_q[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, c_q[k]};

    assign cn_d[k] = add_s[CHUNK];

    assign r_d[k] = (r_q[k] & ~(CHUNK_MASK << (k * CHUNK)))
                  | (WIDTH'(add_s[CHUNK-1:0]) << (k * CHUNK));
  end

  // The carry into the MSB is recovered from the MSB sum bit of the last
  // segment: s = a ^ b ^ cin, so cin = a ^ b ^ s.
  assign msb_cin_s = a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1]
                   ^ r_d[STAGES-1][WIDTH-1];
  assign ovf_d     = msb_cin_s ^ cn_d[STAGES-1];

  // Pipeline registers: the whole pipe shifts one level whenever adv_s is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        r_q[k] <= {WIDTH{1'b0}};
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= {WIDTH{1'b0}};
        b_q[k] <= {WIDTH{1'b0}};
      end
      ovf_q <= 1'b0;
    end else if (adv_s) begin
      // Subtract is a + ~b + 1. The +1 enters as the carry into chunk 0.
      v_q[0] <= in_valid;
      a_q[0] <= a;
      b_q[0] <= sub ? ~b : b;
      c_q[0] <= sub ? 1'b1 : carry_in;
      r_q[0] <= {WIDTH{1'b0}};
      for (int k = 0; k < STAGES; k++) begin
        v_q[k+1] <= v_q[k];
        c_q[k+1] <= cn_d[k];
        r_q[k+1] <= r_d[k];
      end
      for (int k = 1; k < STAGES; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[STAGES];
  assign sum       = r_q[STAGES];
  assign carry_out = c_q[STAGES];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_addsub
//   Directed and streaming checks of pipelined_addsub. The bench uses three
//   instances: 32-bit/4 stages (main), 8-bit/1 stage and 8-bit/8 stages.
//   Inputs are driven and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // main instance, WIDTH=32 STAGES=4
  logic        m_in_valid, m_in_ready, m_cin, m_sub, m_out_valid, m_out_ready;
  logic [31:0] m_a, m_b, m_sum;
  logic        m_cout, m_ovf;

  // 8-bit instances share operands
  logic [7:0]  n_a, n_b;
  logic        n_cin, n_sub, n_out_ready;
  logic        s1_in_valid, s1_in_ready, s1_out_valid, s1_cout, s1_ovf;
  logic [7:0]  s1_sum;
  logic        s8_in_valid, s8_in_ready, s8_out_valid, s8_cout, s8_ovf;
  logic [7:0]  s8_sum;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .carry_in(m_cin), .sub(m_sub),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .sum(m_sum), .carry_out(m_cout), .overflow(m_ovf)
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .a(n_a), .b(n_b), .carry_in(n_cin), .sub(n_sub),
    .out_valid(s1_out_valid), .out_ready(n_out_ready),
    .sum(s1_sum), .carry_out(s1_cout), .overflow(s1_ovf)
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(s8_in_valid), .in_ready(s8_in_ready),
    .a(n_a), .b(n_b), .carry_in(n_cin), .sub(n_sub),
    .out_valid(s8_out_valid), .out_ready(n_out_ready),
    .sum(s8_sum), .carry_out(s8_cout), .overflow(s8_ovf)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic out_valid_of(input int sel);
    case (sel)
      0:       return m_out_valid;
      1:       return s1_out_valid;
      default: return s8_out_valid;
    endcase
  endfunction

  // {overflow, carry_out, sum zero-extended to 32 bits}
  function automatic logic [33:0] result_of(input int sel);
    case (sel)
      0:       return {m_ovf, m_cout, m_sum};
      1:       return {s1_ovf, s1_cout, 24'd0, s1_sum};
      default: return {s8_ovf, s8_cout, 24'd0, s8_sum};
    endcase
  endfunction

  // Reference for the stream: a full-width add, with overflow taken from the signs.
  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s);
    logic [31:0] yy;
    logic [32:0] t;
    logic        ov;
    yy = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + {32'd0, (s ? 1'b1 : ci)};
    ov = (x[31] == yy[31]) && (t[31] != x[31]);
    return {ov, t[32], t[31:0]};
  endfunction

  // Issue one word into instance sel, wait for the result, check latency and value.
  task automatic run_one(input int sel, input logic [31:0] av, input logic [31:0] bv,
                         input logic civ, input logic subv,
                         input logic [31:0] exp_sum, input logic exp_co, input logic exp_ov,
                         input int exp_lat, input string tag);
    int cyc;
    @(negedge clk);
    m_out_ready = 1'b1;
    case (sel)
      0: begin
        m_a = av; m_b = bv; m_cin = civ; m_sub = subv; m_in_valid = 1'b1;
      end
      1: begin
        n_a = av[7:0]; n_b = bv[7:0]; n_cin = civ; n_sub = subv; s1_in_valid = 1'b1;
      end
      default: begin
        n_a = av[7:0]; n_b = bv[7:0]; n_cin = civ; n_sub = subv; s8_in_valid = 1'b1;
      end
    endcase
    @(posedge clk);
    @(negedge clk);
    m_in_valid = 1'b0; s1_in_valid = 1'b0; s8_in_valid = 1'b0;
    cyc = 0;
    while (!out_valid_of(sel) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    check_eq({tag, " result"}, 64'(result_of(sel)), 64'({exp_ov, exp_co, exp_sum}));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sent, recv, extra;
    logic [33:0] exp_q[$];
    logic [33:0] held, exp_w;
    logic        hold_prev, stray;

    rst_n = 1'b0;
    m_in_valid = 1'b0; m_a = 32'd0; m_b = 32'd0; m_cin = 1'b0; m_sub = 1'b0;
    m_out_ready = 1'b1;
    n_a = 8'd0; n_b = 8'd0; n_cin = 1'b0; n_sub = 1'b0; n_out_ready = 1'b1;
    s1_in_valid = 1'b0; s8_in_valid = 1'b0;

    // 1. reset state
    repeat (2) @(negedge clk);
    check_eq("reset out_valid", 64'(m_out_valid), 64'd0);
    check_eq("reset result", 64'(result_of(0)), 64'd0);
    check_eq("reset in_ready", 64'(m_in_ready), 64'd1);
    rst_n = 1'b1;

    // 2./3. directed add and subtract on the main instance
    run_one(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 4, "add wrap");
    run_one(0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 4, "add ovf");
    run_one(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 4, "sub ovf");
    run_one(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 4, "sub borrow");

    // 1b. hold a result under backpressure, then reset asynchronously mid-cycle
    @(negedge clk);
    m_out_ready = 1'b0;
    m_a = 32'h1234_5678; m_b = 32'h0000_0001; m_cin = 1'b0; m_sub = 1'b0; m_in_valid = 1'b1;
    @(negedge clk);
    m_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("held result", 64'({m_out_valid, result_of(0)}), 64'({1'b1, 2'b00, 32'h1234_5679}));
    check_eq("stalled in_ready", 64'(m_in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async rst out_valid", 64'(m_out_valid), 64'd0);
    check_eq("async rst result", 64'(result_of(0)), 64'd0);
    check_eq("async rst in_ready", 64'(m_in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    m_out_ready = 1'b1;

    // 4. random stream with gaps and backpressure
    sent = 0; recv = 0; extra = 0; hold_prev = 1'b0; held = 34'd0;
    for (int cyc = 0; cyc < 5000 && (sent < 200 || exp_q.size() > 0); cyc++) begin
      @(negedge clk);
      if (hold_prev) begin
        check_eq("stall hold", 64'({m_out_valid, result_of(0)}), 64'({1'b1, held}));
      end
      m_in_valid  = (sent < 200) && ($urandom_range(0, 9) < 7);
      m_a         = $urandom;
      m_b         = $urandom;
      m_cin       = 1'($urandom_range(0, 1));
      m_sub       = 1'($urandom_range(0, 1));
      m_out_ready = (sent >= 200) || ($urandom_range(0, 9) < 6);
      #1;
      check_eq("in_ready rule", 64'(m_in_ready), 64'(!(m_out_valid && !m_out_ready)));
      if (m_out_valid && m_out_ready) begin
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          exp_w = exp_q.pop_front();
          check_eq("stream word", 64'(result_of(0)), 64'(exp_w));
          recv++;
        end
      end
      if (m_in_valid && m_in_ready) begin
        exp_q.push_back(ref_add(m_a, m_b, m_cin, m_sub));
        sent++;
      end
      hold_prev = m_out_valid && !m_out_ready;
      held      = result_of(0);
    end
    @(negedge clk);
    m_in_valid  = 1'b0;
    m_out_ready = 1'b1;
    check_eq("stream received", 64'(recv), 64'd200);
    check_eq("stream extra words", 64'(extra), 64'd0);
    check_eq("stream leftover", 64'(exp_q.size()), 64'd0);

    // 5. reset with three words in flight
    repeat (3) @(negedge clk);
    m_a = 32'h0000_0011; m_b = 32'h0000_0022; m_cin = 1'b0; m_sub = 1'b0; m_in_valid = 1'b1;
    repeat (3) @(negedge clk);
    m_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("inflight rst out_valid", 64'(m_out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (m_out_valid) stray = 1'b1;
    end
    check_eq("inflight discarded", 64'(stray), 64'd0);
    run_one(0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 4, "post rst");

    // 6. narrow instances, latency 1 and 8
    run_one(1, 32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1, "s1 add wrap");
    run_one(1, 32'h7F, 32'h00, 1'b1, 1'b0, 32'h80, 1'b0, 1'b1, 1, "s1 add ovf");
    run_one(1, 32'h80, 32'h01, 1'b0, 1'b1, 32'h7F, 1'b1, 1'b1, 1, "s1 sub ovf");
    run_one(1, 32'h05, 32'h07, 1'b1, 1'b1, 32'hFE, 1'b0, 1'b0, 1, "s1 sub borrow");
    run_one(2, 32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 8, "s8 add wrap");
    run_one(2, 32'h7F, 32'h00, 1'b1, 1'b0, 32'h80, 1'b0, 1'b1, 8, "s8 add ovf");
    run_one(2, 32'h80, 32'h01, 1'b0, 1'b1, 32'h7F, 1'b1, 1'b1, 8, "s8 sub ovf");
    run_one(2, 32'h05, 32'h07, 1'b1, 1'b1, 32'hFE, 1'b0, 1'b0, 8, "s8 sub borrow");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
